// File: rtl/sap_pkg.sv
// Shared constants for the SAP controller-sequencer: opcodes, control-word bit positions, T-states.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control word bit positions, MSB first: {CP, EP, LM_n, CE_n, LI_n, EI_n, LA_n, EA, SU, EU, LB_n, LO_n}
  localparam int CON_CP   = 11;
  localparam int CON_EP   = 10;
  localparam int CON_LM_N = 9;
  localparam int CON_CE_N = 8;
  localparam int CON_LI_N = 7;
  localparam int CON_EI_N = 6;
  localparam int CON_LA_N = 5;
  localparam int CON_EA   = 4;
  localparam int CON_SU   = 3;
  localparam int CON_EU   = 2;
  localparam int CON_LB_N = 1;
  localparam int CON_LO_N = 0;

  localparam logic [11:0] CON_IDLE = 12'h3E3;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  function automatic logic op_known(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T1..T6 ring; hold/freeze keep the current state, restart jumps back to T1.
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       hold,
  input  logic       restart,
  input  logic       freeze,
  output logic [5:0] t_state
);

  tstate_e state;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= T1;
    end else if (!(hold || freeze)) begin
      if (restart) begin
        state <= T1;
      end else begin
        case (state)
          T1:      state <= T2;
          T2:      state <= T3;
          T3:      state <= T4;
          T4:      state <= T5;
          T5:      state <= T6;
          default: state <= T1;
        endcase
      end
    end
  end

  assign t_state = state;

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP controller-sequencer: T-state ring plus opcode decode into the 12-bit control word.
module sap_controller_sequencer
  import sap_pkg::*;
#(
  parameter logic EARLY_END = 1'b0,
  parameter int   OPCODE_W  = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [11:0]         con,
  output logic [5:0]          t_state,
  output logic                halted
);

  logic active;
  logic is_t4;
  logic hlt_now;
  logic early;

  assign active  = run && !halted;
  assign is_t4   = (t_state == T4);
  assign hlt_now = active && is_t4 && (opcode == OP_HLT);

  // Early restart only applies to instructions whose remaining T-states would be idle.
  assign early = EARLY_END &&
                 (((t_state == T5) && (opcode == OP_LDA)) ||
                  (is_t4 && ((opcode == OP_OUT) || !op_known(opcode))));

  sap_ring_counter u_ring (
    .clk     (clk),
    .clr     (clr),
    .hold    (!run),
    .restart (early),
    .freeze  (halted || hlt_now),
    .t_state (t_state)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      halted <= 1'b0;
    end else if (hlt_now) begin
      halted <= 1'b1;
    end
  end

  always_comb begin
    con = CON_IDLE;
    if (active) begin
      case (t_state)
        T1: begin
          con[CON_EP]   = 1'b1;
          con[CON_LM_N] = 1'b0;
        end
        T2: con[CON_CP] = 1'b1;
        T3: begin
          con[CON_CE_N] = 1'b0;
          con[CON_LI_N] = 1'b0;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              con[CON_EI_N] = 1'b0;
              con[CON_LM_N] = 1'b0;
            end
            OP_OUT: begin
              con[CON_EA]   = 1'b1;
              con[CON_LO_N] = 1'b0;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              con[CON_CE_N] = 1'b0;
              con[CON_LA_N] = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              con[CON_CE_N] = 1'b0;
              con[CON_LB_N] = 1'b0;
            end
            default: ;
          endcase
        end
        T6: begin
          if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
            con[CON_EU]   = 1'b1;
            con[CON_LA_N] = 1'b0;
            con[CON_SU]   = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Scoreboard bench for sap_controller_sequencer; instance 0 has EARLY_END=0, instance 1 EARLY_END=1.
module tb_sap_controller_sequencer;

  localparam logic [5:0] S1 = 6'b000001, S2 = 6'b000010, S3 = 6'b000100,
                         S4 = 6'b001000, S5 = 6'b010000, S6 = 6'b100000;

  localparam logic [11:0] C_IDLE = 12'h3E3, C_T1 = 12'h5E3, C_T2 = 12'hBE3, C_T3 = 12'h263,
                          C_MEM4 = 12'h1A3, C_LDA5 = 12'h2C3, C_ADD5 = 12'h2E1,
                          C_ADD6 = 12'h3C7, C_SUB6 = 12'h3CF, C_OUT4 = 12'h3F2;

  logic clk = 1'b0;
  logic clr, run;
  logic [3:0] opcode;
  logic [11:0] con0, con1;
  logic [5:0] ts0, ts1;
  logic h0, h1;

  typedef struct packed {
    logic        sel;
    logic [11:0] con;
    logic [5:0]  ts;
    logic        h;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  sap_controller_sequencer #(.EARLY_END(1'b0), .OPCODE_W(4)) dut0 (
    .clk(clk), .clr(clr), .run(run), .opcode(opcode),
    .con(con0), .t_state(ts0), .halted(h0)
  );

  sap_controller_sequencer #(.EARLY_END(1'b1), .OPCODE_W(4)) dut1 (
    .clk(clk), .clr(clr), .run(run), .opcode(opcode),
    .con(con1), .t_state(ts1), .halted(h1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, "/con"}, e.sel ? con1 : con0, e.con);
      check({t, "/t"},   e.sel ? ts1  : ts0,  e.ts);
      check({t, "/h"},   e.sel ? h1   : h0,   e.h);
    end
  end

  always @(negedge clk) begin
    assert ($onehot0({con0[10], ~con0[8], ~con0[6], con0[4], con0[2]}))
      else $error("FAIL bus_excl0: con %0h", con0);
    assert ($onehot0({con1[10], ~con1[8], ~con1[6], con1[4], con1[2]}))
      else $error("FAIL bus_excl1: con %0h", con1);
  end

  // Push the expectation for the current cycle, then let the edge that ends it happen.
  task automatic step(input string tag, input logic sel, input logic [11:0] c,
                      input logic [5:0] t, input logic h);
    exp_q.push_back('{sel: sel, con: c, ts: t, h: h});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b1;
  endtask

  initial begin
    clr = 1'b0; run = 1'b0; opcode = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step("idle0", 1'b0, C_IDLE, S1, 1'b0);
      step("idle1", 1'b1, C_IDLE, S1, 1'b0);
    end

    // LDA with a bogus opcode on the IR during fetch
    run = 1'b1; opcode = 4'hF;
    step("lda_t1", 1'b0, C_T1, S1, 1'b0);
    opcode = 4'h2;
    step("lda_t2", 1'b0, C_T2, S2, 1'b0);
    opcode = 4'h0;
    step("lda_t3", 1'b0, C_T3, S3, 1'b0);
    step("lda_t4", 1'b0, C_MEM4, S4, 1'b0);
    step("lda_t5", 1'b0, C_LDA5, S5, 1'b0);
    step("lda_t6", 1'b0, C_IDLE, S6, 1'b0);
    run = 1'b0;
    step("lda_wrap", 1'b0, C_IDLE, S1, 1'b0);

    do_reset();
    run = 1'b1; opcode = 4'h1;
    step("add_t1", 1'b0, C_T1, S1, 1'b0);
    step("add_t2", 1'b0, C_T2, S2, 1'b0);
    step("add_t3", 1'b0, C_T3, S3, 1'b0);
    step("add_t4", 1'b0, C_MEM4, S4, 1'b0);
    step("add_t5", 1'b0, C_ADD5, S5, 1'b0);
    step("add_t6", 1'b0, C_ADD6, S6, 1'b0);
    opcode = 4'h2;
    step("sub_t1", 1'b0, C_T1, S1, 1'b0);
    step("sub_t2", 1'b0, C_T2, S2, 1'b0);
    step("sub_t3", 1'b0, C_T3, S3, 1'b0);
    step("sub_t4", 1'b0, C_MEM4, S4, 1'b0);
    step("sub_t5", 1'b0, C_ADD5, S5, 1'b0);
    step("sub_t6", 1'b0, C_SUB6, S6, 1'b0);
    step("sub_wrap", 1'b0, C_T1, S1, 1'b0);

    do_reset();
    opcode = 4'hE;
    step("oute_t1", 1'b1, C_T1, S1, 1'b0);
    step("oute_t2", 1'b1, C_T2, S2, 1'b0);
    step("oute_t3", 1'b1, C_T3, S3, 1'b0);
    step("oute_t4", 1'b1, C_OUT4, S4, 1'b0);
    opcode = 4'h0;
    step("ldae_t1", 1'b1, C_T1, S1, 1'b0);
    step("ldae_t2", 1'b1, C_T2, S2, 1'b0);
    step("ldae_t3", 1'b1, C_T3, S3, 1'b0);
    step("ldae_t4", 1'b1, C_MEM4, S4, 1'b0);
    step("ldae_t5", 1'b1, C_LDA5, S5, 1'b0);
    opcode = 4'h5;
    step("nope_t1", 1'b1, C_T1, S1, 1'b0);
    step("nope_t2", 1'b1, C_T2, S2, 1'b0);
    step("nope_t3", 1'b1, C_T3, S3, 1'b0);
    step("nope_t4", 1'b1, C_IDLE, S4, 1'b0);
    step("nope_wrap", 1'b1, C_T1, S1, 1'b0);

    do_reset();
    opcode = 4'hF;
    step("hlt_t1", 1'b0, C_T1, S1, 1'b0);
    step("hlt_t2", 1'b0, C_T2, S2, 1'b0);
    step("hlt_t3", 1'b0, C_T3, S3, 1'b0);
    step("hlt_t4", 1'b0, C_IDLE, S4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      opcode = (i % 2 == 0) ? 4'h1 : 4'hE;
      step("halted", 1'b0, C_IDLE, S4, 1'b1);
    end
    clr = 1'b0;
    step("hlt_clr", 1'b0, C_IDLE, S4, 1'b1);
    clr = 1'b1; opcode = 4'h0;
    step("hlt_resume", 1'b0, C_T1, S1, 1'b0);

    do_reset();
    opcode = 4'h1;
    step("frz_t1", 1'b0, C_T1, S1, 1'b0);
    step("frz_t2", 1'b0, C_T2, S2, 1'b0);
    step("frz_t3", 1'b0, C_T3, S3, 1'b0);
    step("frz_t4", 1'b0, C_MEM4, S4, 1'b0);
    run = 1'b0;
    step("frz_hold", 1'b0, C_IDLE, S5, 1'b0);
    step("frz_hold", 1'b0, C_IDLE, S5, 1'b0);
    run = 1'b1;
    step("frz_t5", 1'b0, C_ADD5, S5, 1'b0);
    step("frz_t6", 1'b0, C_ADD6, S6, 1'b0);
    step("frz_t1b", 1'b0, C_T1, S1, 1'b0);
    step("frz_t2b", 1'b0, C_T2, S2, 1'b0);
    step("frz_t3b", 1'b0, C_T3, S3, 1'b0);
    step("frz_t4b", 1'b0, C_MEM4, S4, 1'b0);
    clr = 1'b0;
    step("mid_clr", 1'b0, C_ADD5, S5, 1'b0);
    clr = 1'b1;
    step("mid_t1", 1'b0, C_T1, S1, 1'b0);

    run = 1'b0;
    repeat (2) @(posedge clk);
    check("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
